// File: rtl/addr_region_checker.sv
// Single-stage address checker: alignment test plus lowest-index inclusive region match,
// registered behind a valid/ready pair, with a saturating fault counter.
// Optional first-fault address capture is enabled by defining ADDR_REGION_CHECKER_FIRST_FAULT_EN.
module addr_region_checker #(
  parameter int XLEN       = 32,
  parameter int REGION_NUM = 4,
  parameter int IALIGN     = 32,
  parameter int ID_WIDTH   = 4,
  parameter int CNT_WIDTH  = 16,
  localparam int RW        = (REGION_NUM > 1) ? $clog2(REGION_NUM) : 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [REGION_NUM*XLEN-1:0] region_left,
  input  logic [REGION_NUM*XLEN-1:0] region_right,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [XLEN-1:0]            req_addr,
  input  logic [1:0]                 req_size,
  input  logic                       req_is_fetch,
  input  logic [ID_WIDTH-1:0]        req_id,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [ID_WIDTH-1:0]        resp_id,
  output logic                       resp_hit,
  output logic [RW-1:0]              resp_region,
  output logic                       resp_misaligned,
  output logic                       resp_fault,
  output logic [CNT_WIDTH-1:0]       fault_cnt,
  input  logic                       cnt_clear
`ifdef ADDR_REGION_CHECKER_FIRST_FAULT_EN
  ,
  output logic                       first_fault_valid,
  output logic [XLEN-1:0]            first_fault_addr
`endif
);

  localparam int FB = $clog2(IALIGN / 8);

  logic            accept;
  logic [XLEN:0]   len;
  logic [XLEN:0]   last;
  logic            wrap;
  logic            mis;
  logic            hit;
  logic [RW-1:0]   idx;
  logic            fault;

  // Handshake: a request transfers when req_valid && req_ready, a response when
  // resp_valid && resp_ready. The output register may be refilled in the same cycle
  // it is drained, so req_ready never inserts a bubble.
  assign req_ready = !resp_valid || resp_ready;
  assign accept    = req_valid && req_ready;

  // Last byte is formed one bit wider so a carry out marks an access that wraps.
  always_comb begin
    len = '0;
    if (req_is_fetch) len = (XLEN+1)'(IALIGN / 8);
    else              len = (XLEN+1)'(1) << req_size;
    last = {1'b0, req_addr} + len - (XLEN+1)'(1);
    wrap = last[XLEN];
  end

  always_comb begin
    mis = 1'b0;
    if (req_is_fetch) begin
      mis = |req_addr[FB-1:0];
    end else begin
      case (req_size)
        2'd1:    mis = req_addr[0];
        2'd2:    mis = |req_addr[1:0];
        2'd3:    mis = |req_addr[2:0];
        default: mis = 1'b0;
      endcase
    end
  end

  // An inverted region (left > right) can never satisfy both bounds, so needs no special case.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = 0; i < REGION_NUM; i++) begin
      if (!hit && !wrap &&
          region_left[i*XLEN +: XLEN] <= req_addr &&
          last[XLEN-1:0] <= region_right[i*XLEN +: XLEN]) begin
        hit = 1'b1;
        idx = RW'(i);
      end
    end
  end

  assign fault = !hit || mis;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      resp_valid      <= 1'b0;
      resp_id         <= '0;
      resp_hit        <= 1'b0;
      resp_region     <= '0;
      resp_misaligned <= 1'b0;
      resp_fault      <= 1'b0;
    end else if (accept) begin
      resp_valid      <= 1'b1;
      resp_id         <= req_id;
      resp_hit        <= hit;
      resp_region     <= idx;
      resp_misaligned <= mis;
      resp_fault      <= fault;
    end else if (resp_ready) begin
      resp_valid      <= 1'b0;
    end
  end

  // A clear coinciding with a counted fault leaves exactly that fault in the counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fault_cnt <= '0;
    end else if (accept && fault) begin
      if (cnt_clear)       fault_cnt <= CNT_WIDTH'(1);
      else if (!(&fault_cnt)) fault_cnt <= fault_cnt + CNT_WIDTH'(1);
    end else if (cnt_clear) begin
      fault_cnt <= '0;
    end
  end

`ifdef ADDR_REGION_CHECKER_FIRST_FAULT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      first_fault_valid <= 1'b0;
      first_fault_addr  <= '0;
    end else if (accept && fault && (cnt_clear || !first_fault_valid)) begin
      first_fault_valid <= 1'b1;
      first_fault_addr  <= req_addr;
    end else if (cnt_clear) begin
      first_fault_valid <= 1'b0;
      first_fault_addr  <= '0;
    end
  end
`else
  // Without first-fault capture only the counter records faults.
`endif

endmodule

// File: tb/tb_addr_region_checker.sv
// Bench for addr_region_checker: directed boundary scenarios plus a randomized run
// against a queue-based reference model; a second instance covers 16-bit fetch alignment.
module tb_addr_region_checker;

  localparam int XLEN = 32;
  localparam int RN   = 4;
  localparam int IW   = 4;
  localparam int CW   = 4;
  localparam int RW   = 2;
  localparam int EW   = IW + RW + 3;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [RN*XLEN-1:0] region_left, region_right;
  logic               req_valid, req_is_fetch, resp_ready, cnt_clear;
  logic [XLEN-1:0]    req_addr;
  logic [1:0]         req_size;
  logic [IW-1:0]      req_id;
  logic               req_ready, resp_valid, resp_hit, resp_misaligned, resp_fault;
  logic [IW-1:0]      resp_id;
  logic [RW-1:0]      resp_region;
  logic [CW-1:0]      fault_cnt;
  logic               r16_req_ready, r16_resp_valid, r16_resp_hit, r16_resp_mis, r16_resp_fault;
  logic [IW-1:0]      r16_resp_id;
  logic [RW-1:0]      r16_resp_region;
  logic [CW-1:0]      r16_fault_cnt;
`ifdef ADDR_REGION_CHECKER_FIRST_FAULT_EN
  logic               first_fault_valid, r16_ffv;
  logic [XLEN-1:0]    first_fault_addr, r16_ffa;
  logic               m_ffv;
  logic [XLEN-1:0]    m_ffa;
`endif

  logic [XLEN-1:0]    lb[RN];
  logic [XLEN-1:0]    rb[RN];
  logic [EW-1:0]      exp_q[$];
  logic [CW-1:0]      m_cnt;
  int                 n_pass = 0;
  int                 n_total = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always_comb begin
    region_left  = '0;
    region_right = '0;
    for (int i = 0; i < RN; i++) begin
      region_left[i*XLEN +: XLEN]  = lb[i];
      region_right[i*XLEN +: XLEN] = rb[i];
    end
  end

  addr_region_checker #(.XLEN(XLEN), .REGION_NUM(RN), .IALIGN(32), .ID_WIDTH(IW), .CNT_WIDTH(CW)) u_dut (
    .clk(clk), .reset_n(reset_n), .region_left(region_left), .region_right(region_right),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_size(req_size),
    .req_is_fetch(req_is_fetch), .req_id(req_id), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_hit(resp_hit), .resp_region(resp_region),
    .resp_misaligned(resp_misaligned), .resp_fault(resp_fault), .fault_cnt(fault_cnt),
    .cnt_clear(cnt_clear)
`ifdef ADDR_REGION_CHECKER_FIRST_FAULT_EN
    , .first_fault_valid(first_fault_valid), .first_fault_addr(first_fault_addr)
`endif
  );

  addr_region_checker #(.XLEN(XLEN), .REGION_NUM(RN), .IALIGN(16), .ID_WIDTH(IW), .CNT_WIDTH(CW)) u_dut16 (
    .clk(clk), .reset_n(reset_n), .region_left(region_left), .region_right(region_right),
    .req_valid(req_valid), .req_ready(r16_req_ready), .req_addr(req_addr), .req_size(req_size),
    .req_is_fetch(req_is_fetch), .req_id(req_id), .resp_valid(r16_resp_valid), .resp_ready(resp_ready),
    .resp_id(r16_resp_id), .resp_hit(r16_resp_hit), .resp_region(r16_resp_region),
    .resp_misaligned(r16_resp_mis), .resp_fault(r16_resp_fault), .fault_cnt(r16_fault_cnt),
    .cnt_clear(cnt_clear)
`ifdef ADDR_REGION_CHECKER_FIRST_FAULT_EN
    , .first_fault_valid(r16_ffv), .first_fault_addr(r16_ffa)
`endif
  );

  // ---------------- reference model ----------------
  // Response packing: {id, hit, region, misaligned, fault}, for a 32-bit-aligned fetch unit.
  function automatic logic [EW-1:0] model_resp(input logic [XLEN-1:0] a, input logic [1:0] s,
                                               input logic f, input logic [IW-1:0] id);
    longint unsigned n, first, last;
    logic            h, m;
    logic [RW-1:0]   rg;
    n     = f ? 64'd4 : (64'd1 << s);
    first = {32'h0, a};
    last  = first + n - 1;
    h     = 1'b0;
    rg    = '0;
    for (int i = 0; i < RN; i++) begin
      if (first >= {32'h0, lb[i]} && last <= {32'h0, rb[i]}) begin
        h  = 1'b1;
        rg = i[RW-1:0];
        break;
      end
    end
    m = (first % n) != 0;
    return {id, h, rg, m, (!h || m)};
  endfunction

  // Advances one clock edge and updates the model from the inputs seen at that edge.
  task automatic tick();
    logic          acc, cons;
    logic [EW-1:0] r;
    cons = (exp_q.size() != 0) && resp_ready;
    acc  = req_valid && ((exp_q.size() == 0) || resp_ready);
    r    = model_resp(req_addr, req_size, req_is_fetch, req_id);
    @(posedge clk);
    if (!reset_n) begin
      exp_q.delete();
      m_cnt = '0;
`ifdef ADDR_REGION_CHECKER_FIRST_FAULT_EN
      m_ffv = 1'b0; m_ffa = '0;
`endif
    end else begin
      if (cons) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(r);
      if (acc && r[0]) m_cnt = cnt_clear ? CW'(1) : ((m_cnt == '1) ? m_cnt : m_cnt + CW'(1));
      else if (cnt_clear) m_cnt = '0;
`ifdef ADDR_REGION_CHECKER_FIRST_FAULT_EN
      if (acc && r[0] && (cnt_clear || !m_ffv)) begin m_ffv = 1'b1; m_ffa = req_addr; end
      else if (cnt_clear) begin m_ffv = 1'b0; m_ffa = '0; end
`endif
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input logic v, input logic [XLEN-1:0] a, input logic [1:0] s,
                         input logic f, input logic [IW-1:0] id);
    req_valid = v; req_addr = a; req_size = s; req_is_fetch = f; req_id = id;
  endtask

  task automatic cfg_ranges();
    lb[0] = 32'h8000_0000; rb[0] = 32'h8000_FFFF;
    lb[1] = 32'h8000_0000; rb[1] = 32'hFFFF_FFFF;
    lb[2] = 32'h1;         rb[2] = 32'h0;
    lb[3] = 32'h1;         rb[3] = 32'h0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; req_valid = 1'b0; cnt_clear = 1'b0; resp_ready = 1'b1;
    repeat (2) tick();
    reset_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    cfg_ranges();
    reset_n = 1'b0; resp_ready = 1'b1; cnt_clear = 1'b0;
    set_req(1'b1, 32'h7FFF_FFFF, 2'd0, 1'b0, 4'hA);
    repeat (3) tick();
    n_total++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %b want 0", resp_valid); else n_pass++;
    n_total++; if (fault_cnt !== '0) $display("FAIL reset_fault_cnt got %0d want 0", fault_cnt); else n_pass++;
    n_total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b want 1", req_ready); else n_pass++;
    n_total++; if ({resp_id, resp_hit, resp_region, resp_misaligned, resp_fault} !== '0)
      $display("FAIL reset_resp_fields got %h want 0", {resp_id, resp_hit, resp_region, resp_misaligned, resp_fault}); else n_pass++;
    reset_n = 1'b1;
    set_req(1'b1, 32'h8000_0010, 2'd2, 1'b0, 4'h5);
    tick();
    n_total++; if (resp_valid !== 1'b1 || resp_id !== 4'h5 || resp_hit !== 1'b1)
      $display("FAIL first_resp got v=%b id=%h hit=%b want v=1 id=5 hit=1", resp_valid, resp_id, resp_hit); else n_pass++;
    set_req(1'b1, 32'h7FFF_FFFF, 2'd0, 1'b0, 4'h6);
    tick();
    n_total++; if (fault_cnt !== CW'(1)) $display("FAIL pre_mid_reset_cnt got %0d want 1", fault_cnt); else n_pass++;
    req_valid = 1'b0; resp_ready = 1'b0; reset_n = 1'b0;
    tick();
    n_total++; if (resp_valid !== 1'b0 || fault_cnt !== '0)
      $display("FAIL mid_reset got v=%b cnt=%0d want v=0 cnt=0", resp_valid, fault_cnt); else n_pass++;
    reset_n = 1'b1; resp_ready = 1'b1;
    tick();
    n_total++; if (resp_valid !== 1'b0) $display("FAIL post_mid_reset_valid got %b want 0", resp_valid); else n_pass++;
  endtask

  task automatic test_ranges();
    logic [XLEN-1:0] a[6]  = '{32'h8000_FFFC, 32'h8000_FFFE, 32'h7FFF_FFFF, 32'h8000_FFFF, 32'h8000_0000, 32'hFFFF_FFF8};
    logic [1:0]      s[6]  = '{2'd2, 2'd2, 2'd0, 2'd0, 2'd3, 2'd3};
    logic            eh[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [RW-1:0]   er[6] = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1};
    logic            em[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset();
    cfg_ranges();
    for (int k = 0; k < 6; k++) begin
      set_req(1'b1, a[k], s[k], 1'b0, IW'(k));
      tick();
      n_total++; if (resp_valid !== 1'b1 || resp_id !== IW'(k) || resp_hit !== eh[k] || resp_region !== er[k] ||
                     resp_misaligned !== em[k] || resp_fault !== (!eh[k] || em[k]))
        $display("FAIL range[%0d] got v=%b id=%h hit=%b reg=%0d mis=%b flt=%b want v=1 id=%h hit=%b reg=%0d mis=%b flt=%b",
                 k, resp_valid, resp_id, resp_hit, resp_region, resp_misaligned, resp_fault,
                 IW'(k), eh[k], er[k], em[k], !eh[k] || em[k]); else n_pass++;
    end
    req_valid = 1'b0;
    tick();
  endtask

  task automatic test_wrap_align();
    logic [XLEN-1:0] a[7]   = '{32'hFFFF_FFFC, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FF01,
                                32'hFFFF_FF02, 32'hFFFF_FFFC, 32'hFFFF_FFFE};
    logic [1:0]      s[7]   = '{2'd2, 2'd2, 2'd0, 2'd1, 2'd3, 2'd0, 2'd1};
    logic            f[7]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic            eh[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic            em[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic            eh16[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic            em16[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    lb[0] = 32'hFFFF_FF00; rb[0] = 32'hFFFF_FFFF;
    for (int i = 1; i < RN; i++) begin lb[i] = 32'h1; rb[i] = 32'h0; end
    resp_ready = 1'b1; cnt_clear = 1'b0;
    for (int k = 0; k < 7; k++) begin
      set_req(1'b1, a[k], s[k], f[k], IW'(k));
      tick();
      n_total++; if (resp_hit !== eh[k] || resp_misaligned !== em[k] || resp_fault !== (!eh[k] || em[k]))
        $display("FAIL wrap32[%0d] got hit=%b mis=%b flt=%b want hit=%b mis=%b flt=%b",
                 k, resp_hit, resp_misaligned, resp_fault, eh[k], em[k], !eh[k] || em[k]); else n_pass++;
      n_total++; if (r16_resp_hit !== eh16[k] || r16_resp_mis !== em16[k])
        $display("FAIL wrap16[%0d] got hit=%b mis=%b want hit=%b mis=%b", k, r16_resp_hit, r16_resp_mis, eh16[k], em16[k]); else n_pass++;
    end
    req_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    cfg_ranges();
    resp_ready = 1'b0;
    set_req(1'b1, 32'h8000_0100, 2'd2, 1'b0, 4'd0);
    tick();
    for (int c = 0; c < 5; c++) begin
      set_req(1'b1, 32'h7FFF_0000, 2'd0, 1'b0, 4'd1);
      #1;
      n_total++; if (req_ready !== 1'b0) $display("FAIL bp_req_ready[%0d] got %b want 0", c, req_ready); else n_pass++;
      n_total++; if (resp_valid !== 1'b1 || resp_id !== 4'd0 || resp_hit !== 1'b1 || resp_region !== 2'd0 || resp_fault !== 1'b0)
        $display("FAIL bp_hold[%0d] got v=%b id=%h hit=%b reg=%0d flt=%b want v=1 id=0 hit=1 reg=0 flt=0",
                 c, resp_valid, resp_id, resp_hit, resp_region, resp_fault); else n_pass++;
      lb[0] = 32'hFFFF_FFFF; rb[0] = 32'h0;
      tick();
    end
    cfg_ranges();
    resp_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      set_req(1'b1, 32'h8000_0000 + XLEN'(k*4), 2'd2, 1'b0, IW'(k));
      tick();
      n_total++; if (resp_valid !== 1'b1 || resp_id !== IW'(k))
        $display("FAIL bp_drain[%0d] got v=%b id=%h want v=1 id=%h", k, resp_valid, resp_id, IW'(k)); else n_pass++;
    end
    req_valid = 1'b0;
    tick();
    n_total++; if (resp_valid !== 1'b0) $display("FAIL bp_empty got %b want 0", resp_valid); else n_pass++;
  endtask

  task automatic test_counter();
    do_reset();
    cfg_ranges();
    resp_ready = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      set_req(1'b1, 32'h7FFF_FFFF, 2'd0, 1'b0, IW'(k));
      tick();
      n_total++; if (fault_cnt !== CW'((k > 15) ? 15 : k))
        $display("FAIL cnt_sat[%0d] got %0d want %0d", k, fault_cnt, (k > 15) ? 15 : k); else n_pass++;
    end
    cnt_clear = 1'b1;
    tick();
    n_total++; if (fault_cnt !== CW'(1)) $display("FAIL cnt_clear_fault got %0d want 1", fault_cnt); else n_pass++;
    req_valid = 1'b0;
    tick();
    n_total++; if (fault_cnt !== '0) $display("FAIL cnt_clear_only got %0d want 0", fault_cnt); else n_pass++;
    cnt_clear = 1'b0; resp_ready = 1'b0;
    set_req(1'b1, 32'h8000_0000, 2'd2, 1'b0, 4'h1);
    tick();
    set_req(1'b1, 32'h7FFF_FFFF, 2'd0, 1'b0, 4'h2);
    tick();
    n_total++; if (fault_cnt !== '0) $display("FAIL cnt_not_accepted got %0d want 0", fault_cnt); else n_pass++;
    resp_ready = 1'b1; req_valid = 1'b0;
    repeat (2) tick();
  endtask

`ifdef ADDR_REGION_CHECKER_FIRST_FAULT_EN
  task automatic test_first_fault();
    do_reset();
    cfg_ranges();
    n_total++; if (first_fault_valid !== 1'b0 || first_fault_addr !== '0)
      $display("FAIL ff_reset got v=%b a=%h want v=0 a=0", first_fault_valid, first_fault_addr); else n_pass++;
    set_req(1'b1, 32'h10, 2'd0, 1'b0, 4'h1); tick();
    set_req(1'b1, 32'h20, 2'd0, 1'b0, 4'h2); tick();
    n_total++; if (first_fault_valid !== 1'b1 || first_fault_addr !== 32'h10)
      $display("FAIL ff_first got v=%b a=%h want v=1 a=10", first_fault_valid, first_fault_addr); else n_pass++;
    req_valid = 1'b0; cnt_clear = 1'b1; tick();
    n_total++; if (first_fault_valid !== 1'b0 || first_fault_addr !== '0)
      $display("FAIL ff_clear got v=%b a=%h want v=0 a=0", first_fault_valid, first_fault_addr); else n_pass++;
    cnt_clear = 1'b0;
    set_req(1'b1, 32'h30, 2'd0, 1'b0, 4'h3); tick();
    n_total++; if (first_fault_addr !== 32'h30) $display("FAIL ff_after_clear got %h want 30", first_fault_addr); else n_pass++;
    cnt_clear = 1'b1;
    set_req(1'b1, 32'h40, 2'd0, 1'b0, 4'h4); tick();
    n_total++; if (first_fault_valid !== 1'b1 || first_fault_addr !== 32'h40)
      $display("FAIL ff_clear_and_fault got v=%b a=%h want v=1 a=40", first_fault_valid, first_fault_addr); else n_pass++;
    cnt_clear = 1'b0; req_valid = 1'b0; tick();
  endtask
`endif

  task automatic test_random();
    int k;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (c == 0 || $urandom_range(0, 9) == 0) begin
        for (int i = 0; i < RN; i++) begin
          lb[i] = $urandom;
          rb[i] = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : lb[i] + XLEN'($urandom_range(0, 'h400)) - 32'h8;
        end
        if ($urandom_range(0, 1) == 1) lb[1] = lb[0];
      end
      k = $urandom_range(0, RN - 1);
      req_valid    = ($urandom_range(0, 3) != 0);
      resp_ready   = ($urandom_range(0, 3) != 0);
      cnt_clear    = ($urandom_range(0, 15) == 0);
      req_size     = 2'($urandom_range(0, 3));
      req_is_fetch = ($urandom_range(0, 3) == 0);
      req_id       = IW'($urandom);
      case ($urandom_range(0, 2))
        0:       req_addr = lb[k] + XLEN'($urandom_range(0, 8)) - 32'h4;
        1:       req_addr = rb[k] + XLEN'($urandom_range(0, 8)) - 32'h4;
        default: req_addr = $urandom;
      endcase
      #1;
      n_total++; if (req_ready !== ((exp_q.size() == 0) || resp_ready))
        $display("FAIL rnd_req_ready[%0d] got %b want %b", c, req_ready, (exp_q.size() == 0) || resp_ready); else n_pass++;
      tick();
      n_total++; if (resp_valid !== (exp_q.size() != 0))
        $display("FAIL rnd_resp_valid[%0d] got %b want %b", c, resp_valid, exp_q.size() != 0); else n_pass++;
      if (exp_q.size() != 0) begin
        n_total++; if ({resp_id, resp_hit, resp_region, resp_misaligned, resp_fault} !== exp_q[0])
          $display("FAIL rnd_resp[%0d] got %h want %h", c, {resp_id, resp_hit, resp_region, resp_misaligned, resp_fault}, exp_q[0]); else n_pass++;
      end
      n_total++; if (fault_cnt !== m_cnt) $display("FAIL rnd_cnt[%0d] got %0d want %0d", c, fault_cnt, m_cnt); else n_pass++;
`ifdef ADDR_REGION_CHECKER_FIRST_FAULT_EN
      n_total++; if (first_fault_valid !== m_ffv || first_fault_addr !== m_ffa)
        $display("FAIL rnd_ff[%0d] got v=%b a=%h want v=%b a=%h", c, first_fault_valid, first_fault_addr, m_ffv, m_ffa); else n_pass++;
`endif
    end
    req_valid = 1'b0; cnt_clear = 1'b0; resp_ready = 1'b1;
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    m_cnt = '0;
`ifdef ADDR_REGION_CHECKER_FIRST_FAULT_EN
    m_ffv = 1'b0; m_ffa = '0;
`endif
    reset_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_size = '0; req_is_fetch = 1'b0;
    req_id = '0; resp_ready = 1'b1; cnt_clear = 1'b0;
    test_reset();
    test_ranges();
    test_wrap_align();
    test_backpressure();
    test_counter();
`ifdef ADDR_REGION_CHECKER_FIRST_FAULT_EN
    test_first_fault();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
